add_pipe: RTL and testbench
===========================

Name: add_pipe

Overview:
- Parametrised, pipelined successor to the single-bit adder: WIDTH-bit add/subtract of a and b with carry-in and carry-out.
- Operands are split into STAGES equal chunks, one chunk resolved per pipeline stage, with the carry registered between stages.
- Valid/ready handshake on input and output; one operation accepted per cycle at full throughput.
- Used as the arithmetic primitive for the team's datapath blocks.

Parameters:
WIDTH, 8, operand/result width in bits; must be a multiple of STAGES, at least 1
STAGES, 2, pipeline stages = operand chunks; 1..WIDTH; chunk width CW = WIDTH/STAGES

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous reset, active-high
in_valid  input  1  operand transfer request
in_ready  output  1  block can accept operands this cycle
a  input  WIDTH  operand A, unsigned or two's complement
b  input  WIDTH  operand B
cin  input  1  carry-in for add; ignored when sub=1
sub  input  1  0: a+b+cin; 1: a-b (a + ~b + 1)
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
sum  output  WIDTH  result, modulo 2^WIDTH
cout  output  1  carry out of MSB; for sub, 1 = no borrow (a >= b unsigned)

Behaviour:
- One clock (clk); reset is asynchronous and active-high (rst). All registers clear immediately on rst=1, independent of clk.
- Reset values:
  - out_valid=0, sum=0, cout=0.
  - All internal stage valid bits 0; all data and carry registers 0.
  - in_ready=1 from the first cycle after rst deasserts.
- Input transfer: in_valid && in_ready at a rising edge.
- Output transfer: out_valid && out_ready at a rising edge.
- Stage k (0..STAGES-1):
  - Adds chunk k of a and b' plus the carry from stage k-1. b' = ~b when sub=1, else b.
  - Stage 0 carry-in is sub ? 1 : cin.
  - Stage 0 registers: CW-bit partial sum, carry, the unused upper chunks of a and b', and a valid bit.
  - Chunks not yet consumed travel forward unmodified. Already-computed lower sum chunks are delayed so that all chunks arrive at the last stage aligned.
- Latency: an operand accepted at edge N appears on sum/cout with out_valid=1 after edge N+STAGES-1, i.e. STAGES registered stages.
- Throughput: one result per cycle when out_ready is held at 1.
- Flow control, per-stage, bubble-collapsing:
  - stage_ready[STAGES-1] = !valid[STAGES-1] || out_ready.
  - stage_ready[k] = !valid[k] || stage_ready[k+1].
  - in_ready = stage_ready[0], combinational from out_ready and the valid bits; no combinational path from in_valid.
  - A stage loads from its predecessor when its stage_ready is 1. Its valid bit becomes the predecessor's valid, or in_valid for stage 0.
- Stall: while out_valid=1 and out_ready=0, sum, cout and out_valid hold stable. Pipeline capacity is STAGES operations; no operation is lost or reordered.
- Simultaneous accept and output on the same edge with a full pipeline is legal and sustains throughput.
- Reset mid-operation: in-flight operations are discarded; no stale result appears after rst deasserts.
- STAGES=1: single-register adder with latency 1; same handshake rules.
- No internal state other than the pipeline; the block does not accumulate.

Optional Feature:
- Macro: ADD_PIPE_OVF_EN.
- Defined:
  - Adds output port ovf (1 bit).
  - ovf = signed two's-complement overflow of the operation: carry into MSB XOR carry out of MSB, computed in the last stage.
  - ovf is registered and aligned with sum; reset value 0; held stable under stall.
- Not defined: ovf port and its logic are absent; all other behaviour is identical.

Test Plan:
- Add across chunk boundary (WIDTH=8, STAGES=2, out_ready=1): a=0x0F, b=0x01, cin=0, sub=0 -> sum=0x10, cout=0, out_valid for exactly one cycle, 2 cycles after accept. Then a=0xFF, b=0x01 -> sum=0x00, cout=1.
- Subtract: a=0x07, b=0x05, sub=1, cin=1 -> sum=0x02, cout=1. Then a=0x05, b=0x07, sub=1 -> sum=0xFE, cout=0 (cin ignored).
- Backpressure: 4 back-to-back operations (1+1, 2+2, 3+3, 4+4) with out_ready=0 for the first 4 cycles:
  - in_ready drops to 0 once 2 operations are held.
  - sum stays at 0x02 while stalled.
  - After out_ready=1, results 0x02, 0x04, 0x06, 0x08 appear in order, none lost or duplicated.
- Bubble collapse: single operation 0x10+0x20 followed by idle cycles, out_ready toggling 0/1 every cycle -> exactly one out_valid transfer of sum=0x30.
- Asynchronous reset with 2 operations in flight: out_valid and sum go to 0 before the next clk edge. After rst deasserts, out_valid stays 0 and in_ready=1.
- With ADD_PIPE_OVF_EN defined:
  - 0x7F+0x01 -> sum=0x80, ovf=1.
  - 0x80-0x01 -> sum=0x7F, ovf=1.
  - 0x10+0x20 -> ovf=0.
  - Rerun all scenarios with STAGES=1 and STAGES=4 (WIDTH=8); latency must equal STAGES.

Source files
------------

// File: rtl/add_pipe_if.sv
// Operand/result handshake bundle for add_pipe.
// The ovf signal exists only when ADD_PIPE_OVF_EN is defined.
interface add_pipe_if #(
  parameter int WIDTH = 8
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef ADD_PIPE_OVF_EN
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );
  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
`else
  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout
  );
  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout
  );
`endif
endinterface

// File: rtl/add_pipe.sv
// Pipelined WIDTH-bit add/subtract, one CW-bit chunk per stage, with per-stage valid/ready.
// Optional signed-overflow output enabled by defining ADD_PIPE_OVF_EN.
module add_pipe #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  add_pipe_if.slave  bus
);
  localparam int CW = WIDTH / STAGES;
  localparam int L  = STAGES - 1;

  logic [STAGES-1:0]            vld_pk;
  logic [STAGES-1:0]            carry_pk;
  logic [STAGES-1:0]            rdy;
  logic [STAGES-1:0][WIDTH-1:0] a_pk;
  logic [STAGES-1:0][WIDTH-1:0] b_pk;
  logic [STAGES-1:0][WIDTH-1:0] sum_pk;

  logic [STAGES-1:0][WIDTH-1:0] a_i;
  logic [STAGES-1:0][WIDTH-1:0] b_i;
  logic [STAGES-1:0][WIDTH-1:0] s_i;
  logic [STAGES-1:0][WIDTH-1:0] s_n;
  logic [STAGES-1:0]            c_i;
  logic [STAGES-1:0]            c_n;
  logic [STAGES-1:0]            v_i;
  logic [CW:0]                  r;
`ifdef ADD_PIPE_OVF_EN
  logic                         ovf_n;
  logic                         ovf_pk;
`endif
  logic                         unused_bits;

  function automatic logic [CW:0] chunk_add(input logic [CW-1:0] x,
                                            input logic [CW-1:0] y,
                                            input logic          c);
    return {1'b0, x} + {1'b0, y} + {{CW{1'b0}}, c};
  endfunction

  // A stage can load when it, or any stage downstream of it, has a free slot.
  always_comb begin : flow
    logic acc;
    acc = 1'b0;
    rdy = '0;
    for (int k = 0; k < STAGES; k++) begin
      acc = bus.out_ready;
      for (int j = k; j < STAGES; j++) acc = acc | ~vld_pk[j];
      rdy[k] = acc;
    end
  end

  always_comb begin : datapath
    a_i = '0;
    b_i = '0;
    s_i = '0;
    s_n = '0;
    c_i = '0;
    c_n = '0;
    v_i = '0;
    r   = '0;
    a_i[0] = bus.a;
    b_i[0] = bus.sub ? ~bus.b : bus.b;
    c_i[0] = bus.sub | bus.cin;
    v_i[0] = bus.in_valid;
    for (int k = 1; k < STAGES; k++) begin
      a_i[k] = a_pk[k-1];
      b_i[k] = b_pk[k-1];
      s_i[k] = sum_pk[k-1];
      c_i[k] = carry_pk[k-1];
      v_i[k] = vld_pk[k-1];
    end
    for (int k = 0; k < STAGES; k++) begin
      r                   = chunk_add(a_i[k][k*CW +: CW], b_i[k][k*CW +: CW], c_i[k]);
      s_n[k]              = s_i[k];
      s_n[k][k*CW +: CW]  = r[CW-1:0];
      c_n[k]              = r[CW];
    end
`ifdef ADD_PIPE_OVF_EN
    // MSB sum bit = a ^ b' ^ carry-in, so the carry into the MSB falls out of the XOR.
    ovf_n = a_i[L][WIDTH-1] ^ b_i[L][WIDTH-1] ^ s_n[L][WIDTH-1] ^ c_n[L];
`endif
  end

  // ---- stage registers: stage k resolves chunk k, all else rides along ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pk   <= '0;
      carry_pk <= '0;
      a_pk     <= '0;
      b_pk     <= '0;
      sum_pk   <= '0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (rdy[k]) begin
          vld_pk[k]   <= v_i[k];
          carry_pk[k] <= c_n[k];
          a_pk[k]     <= a_i[k];
          b_pk[k]     <= b_i[k];
          sum_pk[k]   <= s_n[k];
        end
      end
    end
  end

`ifdef ADD_PIPE_OVF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         ovf_pk <= 1'b0;
    else if (rdy[L]) ovf_pk <= ovf_n;
  end

  assign bus.ovf = ovf_pk;
`endif

  // Operand copies in the last stage have no consumer.
  assign unused_bits   = ^{a_pk[L], b_pk[L]};

  assign bus.in_ready  = rdy[0];
  assign bus.out_valid = vld_pk[L];
  assign bus.sum       = sum_pk[L];
  assign bus.cout      = carry_pk[L];
endmodule

// File: tb/tb_add_pipe.sv
// Scoreboard bench for add_pipe: expected results queued on accept, compared on output transfer.
module tb_add_pipe #(
  parameter int STAGES = 2
);
  localparam int WIDTH = 8;

  typedef struct packed {
    logic [7:0] s;
    logic       c;
    logic       o;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  add_pipe_if #(.WIDTH(WIDTH)) bus ();

  add_pipe #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_deliv  = 0;
  logic accepted;
  logic delivered;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [7:0] a, input logic [7:0] b,
                                 input logic ci, input logic sb);
    logic [7:0] bb;
    logic [8:0] full;
    exp_t       e;
    bb   = sb ? ~b : b;
    full = {1'b0, a} + {1'b0, bb} + {8'd0, (sb ? 1'b1 : ci)};
    e.s  = full[7:0];
    e.c  = full[8];
    e.o  = (a[7] == bb[7]) && (full[7] != a[7]);
    return e;
  endfunction

  // Drive one cycle at the falling edge, then judge what the next rising edge will transfer.
  task automatic cycle(input logic v, input logic [7:0] a, input logic [7:0] b,
                       input logic ci, input logic sb, input logic ordy);
    exp_t e;
    @(negedge clk);
    bus.in_valid  = v;
    bus.a         = a;
    bus.b         = b;
    bus.cin       = ci;
    bus.sub       = sb;
    bus.out_ready = ordy;
    #1;
    accepted  = v && bus.in_ready;
    delivered = bus.out_valid && ordy;
    if (delivered) begin
      n_deliv++;
      check_val("sb_pending", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_val("sum", 32'(bus.sum), 32'(e.s));
        check_val("cout", 32'(bus.cout), 32'(e.c));
`ifdef ADD_PIPE_OVF_EN
        check_val("ovf", 32'(bus.ovf), 32'(e.o));
`endif
      end
    end
    if (accepted) exp_q.push_back(model(a, b, ci, sb));
  endtask

  task automatic idle(input logic ordy);
    cycle(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, ordy);
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && exp_q.size() > 0; i++) idle(1'b1);
    check_val("drained", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int   lat;
    logic seen;
    int   idx;
    int   held;
    int   d0;

    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.cin       = 1'b0;
    bus.sub       = 1'b0;
    bus.out_ready = 1'b0;
    rst           = 1'b1;
    accepted      = 1'b0;
    delivered     = 1'b0;

    @(negedge clk);
    #1;
    check_val("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check_val("rst_sum", 32'(bus.sum), 32'd0);
    check_val("rst_cout", 32'(bus.cout), 32'd0);
`ifdef ADD_PIPE_OVF_EN
    check_val("rst_ovf", 32'(bus.ovf), 32'd0);
`endif
    @(negedge clk);
    rst = 1'b0;
    idle(1'b1);
    check_val("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

    // Carry across the chunk boundary, latency and single-cycle valid
    cycle(1'b1, 8'h0F, 8'h01, 1'b0, 1'b0, 1'b1);
    check_val("acc_first", 32'(accepted), 32'd1);
    lat  = 0;
    seen = 1'b0;
    for (int i = 0; i < STAGES + 3 && !seen; i++) begin
      idle(1'b1);
      lat++;
      if (delivered) seen = 1'b1;
    end
    check_val("latency", 32'(lat), 32'(STAGES));
    idle(1'b1);
    check_val("valid_one_cycle", 32'(bus.out_valid), 32'd0);

    cycle(1'b1, 8'hFF, 8'h01, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 8'h07, 8'h05, 1'b1, 1'b1, 1'b1);
    cycle(1'b1, 8'h05, 8'h07, 1'b1, 1'b1, 1'b1);
    cycle(1'b1, 8'h7F, 8'h01, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 8'h80, 8'h01, 1'b0, 1'b1, 1'b1);
    cycle(1'b1, 8'h10, 8'h20, 1'b0, 1'b0, 1'b1);
    drain();

    // Full throughput with out_ready held high
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 8'($urandom_range(255, 0)), 8'($urandom_range(255, 0)),
            1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), 1'b1);
      check_val("tput_acc", 32'(accepted), 32'd1);
      if (i >= STAGES) check_val("tput_out", 32'(delivered), 32'd1);
    end
    drain();

    // Backpressure: four operations, output stalled for four cycles
    idx  = 0;
    held = 0;
    d0   = n_deliv;
    for (int c = 0; c < 4; c++) begin
      cycle(idx < 4, 8'(idx + 1), 8'(idx + 1), 1'b0, 1'b0, 1'b0);
      check_val("bp_in_ready", 32'(bus.in_ready), 32'(held < STAGES));
      if (bus.out_valid) check_val("bp_hold_sum", 32'(bus.sum), 32'h02);
      if (accepted) begin
        idx++;
        held++;
      end
    end
    for (int c = 0; c < 40 && (idx < 4 || exp_q.size() > 0); c++) begin
      cycle(idx < 4, 8'(idx + 1), 8'(idx + 1), 1'b0, 1'b0, 1'b1);
      if (accepted) idx++;
    end
    check_val("bp_all_sent", 32'(idx), 32'd4);
    check_val("bp_count", 32'(n_deliv - d0), 32'd4);
    drain();

    // Single operation through bubbles with out_ready toggling
    d0 = n_deliv;
    cycle(1'b1, 8'h10, 8'h20, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 14; i++) idle(1'(i % 2));
    check_val("bubble_count", 32'(n_deliv - d0), 32'd1);
    drain();

    // Random traffic on both sides
    for (int i = 0; i < 300; i++) begin
      cycle(1'($urandom_range(3, 0) != 0), 8'($urandom_range(255, 0)), 8'($urandom_range(255, 0)),
            1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)));
    end
    drain();

    // Asynchronous reset with operations in flight
    cycle(1'b1, 8'h03, 8'h04, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 8'h05, 8'h06, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < STAGES; i++) idle(1'b0);
    check_val("pre_rst_valid", 32'(bus.out_valid), 32'd1);
    #1;
    rst = 1'b1;
    #1;
    check_val("async_rst_valid", 32'(bus.out_valid), 32'd0);
    check_val("async_rst_sum", 32'(bus.sum), 32'd0);
    check_val("async_rst_cout", 32'(bus.cout), 32'd0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < STAGES + 2; i++) begin
      idle(1'b1);
      check_val("post_rst_no_stale", 32'(bus.out_valid), 32'd0);
      check_val("post_rst_ready", 32'(bus.in_ready), 32'd1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
